// File: rtl/opb_register_bank_ppc2simulink_if.sv
// -----------------------------------------------------------------------------
// opb_register_bank_ppc2simulink_if
//
// Purpose : Groups the OPB slave-side transfer signals used by the register
//           bank. Bit numbering follows the IBM/OPB convention: bit 0 is MSB.
//
// Signals :
//   OPB_ABus    [0:31]  byte address from the master
//   OPB_BE      [0:3]   byte enables, BE[0] qualifies DBus[0:7]
//   OPB_DBus    [0:31]  write data from the master
//   OPB_RNW             1 = read, 0 = write
//   OPB_select          transfer request
//   OPB_seqAddr         sequential burst hint
//   Sl_DBus     [0:31]  slave read data (wired-OR, zero when idle)
//   Sl_xferAck          slave transfer acknowledge
//   Sl_errAck           slave error acknowledge
//   Sl_retry            slave retry request
//   Sl_toutSup          slave timeout suppress
//
// Modports: master (bus side driving requests), slave (register bank).
// -----------------------------------------------------------------------------
interface opb_register_bank_ppc2simulink_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_bank_ppc2simulink.sv
// -----------------------------------------------------------------------------
// opb_register_bank_ppc2simulink
//
// Purpose : OPB slave exposing NUM_REGS software-writable 32-bit control
//           registers to fabric logic running on the bus clock. Supports
//           byte-enable writes, readback and a per-register change strobe.
//
// Ports   :
//   OPB_Clk          bus and user clock
//   OPB_Rst_n        synchronous, active-low reset
//   opb              OPB slave interface (see opb_register_bank_ppc2simulink_if)
//   user_data_out_o  register i on bits [32*i+31:32*i]
//   user_strobe_o    1-cycle pulse when register i output changes by a write
//
// Configuration macro: REGBANK_SHADOW_EN
//   Defined   : writes land in shadow registers; a write to byte offset
//               NUM_REGS*4 (the commit register) copies all shadows to the
//               outputs on one edge. Reads return shadow values; the commit
//               register reads 0.
//   Undefined : writes update the outputs directly; offset NUM_REGS*4 behaves
//               like any other unpopulated word in the decoded window.
//
// Timing  : a hit in cycle n is acknowledged in cycle n+1. Write data and
//           byte enables are sampled in cycle n, so outputs and strobes are
//           visible in cycle n+1, together with the acknowledge.
// -----------------------------------------------------------------------------
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h01003600,
  parameter logic [31:0] C_HIGHADDR   = 32'h010036FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          NUM_REGS     = 8,
  parameter logic [31:0] RESET_VALUE  = 32'h0
) (
  input  logic                               OPB_Clk,
  input  logic                               OPB_Rst_n,
  opb_register_bank_ppc2simulink_if.slave    opb,
  output logic [NUM_REGS*32-1:0]             user_data_out_o,
  output logic [NUM_REGS-1:0]                user_strobe_o
);

  // ---------------------------------------------------------------------------
  // Transfer FSM: IDLE accepts a request, ACK drives the acknowledge, GAP
  // swallows one cycle so a select that is still high is not acked twice.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Register storage
  logic [31:0]          reg_q    [NUM_REGS];
  logic [31:0]          reg_d    [NUM_REGS];
`ifdef REGBANK_SHADOW_EN
  logic [31:0]          shadow_q [NUM_REGS];
  logic [31:0]          shadow_d [NUM_REGS];
`endif
  logic [NUM_REGS-1:0]  strobe_q, strobe_d;
  logic [31:0]          rd_q, rd_d;

  // ---------------------------------------------------------------------------
  // Address decode. The OPB buses are MSB-first; copying them into [N-1:0]
  // vectors keeps the numeric value, so arithmetic works directly.
  // ---------------------------------------------------------------------------
  logic [C_OPB_AWIDTH-1:0] addr;
  logic [C_OPB_DWIDTH-1:0] wdata;
  logic [31:0]             offset;
  logic [31:0]             word_idx;
  logic                    hit;
  logic                    accept;

  assign addr     = opb.OPB_ABus;
  assign wdata    = opb.OPB_DBus;
  assign offset   = addr - C_BASEADDR;
  assign word_idx = offset >> 2;
  assign hit      = opb.OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  // A new transfer is only taken from IDLE; ACK and GAP ignore the bus.
  assign accept   = (state_q == S_IDLE) && hit;

  // Byte-lane merge: BE[k] selects the k-th byte counted from the MSB.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [0:3]  be);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[31-8*k -: 8] = new_val[31-8*k -: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (hit) state_d = S_ACK;
      // Sequential bursts return straight to IDLE for back-to-back beats.
      S_ACK:   state_d = opb.OPB_seqAddr ? S_IDLE : S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register write / readback datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    reg_d    = reg_q;
`ifdef REGBANK_SHADOW_EN
    shadow_d = shadow_q;
`endif
    strobe_d = '0;
    rd_d     = rd_q;

    if (accept) begin
      if (opb.OPB_RNW) begin
        // Unpopulated words (including the commit register) read as zero.
        rd_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (word_idx == 32'(i)) begin
`ifdef REGBANK_SHADOW_EN
            rd_d = shadow_q[i];
`else
            rd_d = reg_q[i];
`endif
          end
        end
      end else begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (word_idx == 32'(i)) begin
`ifdef REGBANK_SHADOW_EN
            shadow_d[i] = lane_merge(shadow_q[i], wdata, opb.OPB_BE);
`else
            reg_d[i]    = lane_merge(reg_q[i], wdata, opb.OPB_BE);
            // Strobe only on a real change, so BE=0 or rewriting the same
            // value is silent.
            strobe_d[i] = (reg_d[i] != reg_q[i]);
`endif
          end
        end
`ifdef REGBANK_SHADOW_EN
        // Commit register: data is ignored, every shadow moves on this edge.
        if (word_idx == 32'(NUM_REGS)) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            reg_d[i]    = shadow_q[i];
            strobe_d[i] = (shadow_q[i] != reg_q[i]);
          end
        end
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge OPB_Clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its inputs regardless of order.
    if (!OPB_Rst_n) begin
      state_q  <= S_IDLE;
      strobe_q <= '0;
      rd_q     <= '0;
      // NOTE: the register array is a handful of flops, not a RAM, so it is
      // reset explicitly to give software a known starting value.
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i]    <= RESET_VALUE;
`ifdef REGBANK_SHADOW_EN
        shadow_q[i] <= RESET_VALUE;
`endif
      end
    end else begin
      state_q  <= state_d;
      strobe_q <= strobe_d;
      rd_q     <= rd_d;
      reg_q    <= reg_d;
`ifdef REGBANK_SHADOW_EN
      shadow_q <= shadow_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Reset is sampled synchronously for state, but the bus-facing
  // acknowledge, data and strobes are also masked while reset is low so an
  // in-flight transfer is aborted without an ack.
  // ---------------------------------------------------------------------------
  logic ack_active;
  assign ack_active = (state_q == S_ACK) && OPB_Rst_n;

  assign opb.Sl_xferAck = ack_active;
  assign opb.Sl_DBus    = ack_active ? rd_q : 32'h0;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

  assign user_strobe_o  = strobe_q & {NUM_REGS{OPB_Rst_n}};

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign user_data_out_o[32*g +: 32] = reg_q[g];
  end

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// -----------------------------------------------------------------------------
// tb_opb_register_bank_ppc2simulink
//
// Directed bench for the OPB register bank (NUM_REGS=8, RESET_VALUE=0).
// Inputs are driven on the falling edge; outputs are sampled 1 ns after the
// rising edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_opb_register_bank_ppc2simulink;

  localparam int          NR   = 8;
  localparam logic [31:0] BASE = 32'h01003600;
  localparam logic [31:0] HIGH = 32'h010036FF;

  logic            clk;
  logic            rst_n;
  logic [NR*32-1:0] user_data_out;
  logic [NR-1:0]   user_strobe;

  int checks = 0;
  int errors = 0;

  opb_register_bank_ppc2simulink_if ifc ();

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR   (BASE),
    .C_HIGHADDR   (HIGH),
    .C_OPB_AWIDTH (32),
    .C_OPB_DWIDTH (32),
    .NUM_REGS     (NR),
    .RESET_VALUE  (32'h0)
  ) dut (
    .OPB_Clk         (clk),
    .OPB_Rst_n       (rst_n),
    .opb             (ifc.slave),
    .user_data_out_o (user_data_out),
    .user_strobe_o   (user_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer with seqAddr=0; returns ack status, latency in cycles and
  // the bus/user outputs seen in the ack cycle. Bounded to 16 cycles.
  task automatic xfer(input  logic [31:0]      a,
                      input  logic             rnw,
                      input  logic [31:0]      d,
                      input  logic [3:0]       be,
                      output logic             acked,
                      output int               lat,
                      output logic [31:0]      rdata,
                      output logic [NR-1:0]    strb,
                      output logic [NR*32-1:0] udata);
    acked = 1'b0;
    lat   = 0;
    rdata = '0;
    strb  = '0;
    udata = '0;
    repeat (3) @(negedge clk);
    ifc.OPB_ABus    = a;
    ifc.OPB_RNW     = rnw;
    ifc.OPB_DBus    = d;
    ifc.OPB_BE      = be;
    ifc.OPB_seqAddr = 1'b0;
    ifc.OPB_select  = 1'b1;
    for (int c = 1; c <= 16 && !acked; c++) begin
      @(posedge clk); #1;
      if (ifc.Sl_xferAck) begin
        acked = 1'b1;
        lat   = c;
        rdata = ifc.Sl_DBus;
        strb  = user_strobe;
        udata = user_data_out;
      end
    end
    ifc.OPB_select = 1'b0;
    ifc.OPB_RNW    = 1'b1;
    ifc.OPB_DBus   = '0;
    ifc.OPB_BE     = '0;
  endtask

  logic             acked;
  int               lat;
  logic [31:0]      rdata;
  logic [NR-1:0]    strb;
  logic [NR*32-1:0] udata;
  logic [NR*32-1:0] exp_u;
  logic [4:0]       ack_pat;

  initial begin
    ifc.OPB_ABus    = '0;
    ifc.OPB_BE      = '0;
    ifc.OPB_DBus    = '0;
    ifc.OPB_RNW     = 1'b1;
    ifc.OPB_select  = 1'b0;
    ifc.OPB_seqAddr = 1'b0;
    rst_n           = 1'b0;

    // ---- 1: reset held for 3 cycles ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_udata",  256'(user_data_out), 256'h0);
    check("rst_ack",    256'(ifc.Sl_xferAck), 256'h0);
    check("rst_dbus",   256'(ifc.Sl_DBus), 256'h0);
    check("rst_strobe", 256'(user_strobe), 256'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- 2: full-word write to reg2, then readback ----
    xfer(BASE + 32'h8, 1'b0, 32'hDEADBEEF, 4'b1111, acked, lat, rdata, strb, udata);
    check("wr2_ack", 256'(acked), 256'h1);
    check("wr2_lat", 256'(lat), 256'h1);
`ifdef REGBANK_SHADOW_EN
    check("wr2_shadow_hold", 256'(udata), 256'h0);
    check("wr2_shadow_strb", 256'(strb), 256'h0);
    xfer(BASE + 32'h20, 1'b0, 32'h0, 4'b1111, acked, lat, rdata, strb, udata);
    check("commit2_ack", 256'(acked), 256'h1);
`endif
    exp_u = '0;
    exp_u[95:64] = 32'hDEADBEEF;
    check("wr2_udata",  256'(udata), 256'(exp_u));
    check("wr2_strobe", 256'(strb), 256'h04);
    @(posedge clk); #1;
    check("wr2_strobe_pulse", 256'(user_strobe), 256'h0);
    xfer(BASE + 32'h8, 1'b1, 32'h0, 4'b1111, acked, lat, rdata, strb, udata);
    check("rd2_ack",  256'(acked), 256'h1);
    check("rd2_data", 256'(rdata), 256'hDEADBEEF);
    @(posedge clk); #1;
    check("rd2_dbus_idle", 256'(ifc.Sl_DBus), 256'h0);

    // ---- 3: byte-lane write BE=0101 ----
    xfer(BASE + 32'h8, 1'b0, 32'h11223344, 4'b0101, acked, lat, rdata, strb, udata);
`ifdef REGBANK_SHADOW_EN
    xfer(BASE + 32'h20, 1'b0, 32'h0, 4'b1111, acked, lat, rdata, strb, udata);
`endif
    exp_u[95:64] = 32'hDE22BE44;
    check("be_udata",  256'(udata), 256'(exp_u));
    check("be_strobe", 256'(strb), 256'h04);

    // BE=0 still acks, changes nothing, no strobe
    xfer(BASE + 32'h8, 1'b0, 32'hFFFFFFFF, 4'b0000, acked, lat, rdata, strb, udata);
    check("be0_ack",    256'(acked), 256'h1);
    check("be0_udata",  256'(udata), 256'(exp_u));
    check("be0_strobe", 256'(strb), 256'h0);

    // ---- 4: unpopulated word inside window, out-of-range addresses ----
    xfer(BASE + 32'h7C, 1'b1, 32'h0, 4'b1111, acked, lat, rdata, strb, udata);
    check("oob_rd_ack",  256'(acked), 256'h1);
    check("oob_rd_data", 256'(rdata), 256'h0);
    xfer(BASE + 32'h7C, 1'b0, 32'hCAFEF00D, 4'b1111, acked, lat, rdata, strb, udata);
    check("oob_wr_ack",    256'(acked), 256'h1);
    check("oob_wr_strobe", 256'(strb), 256'h0);
    check("oob_wr_udata",  256'(udata), 256'(exp_u));
    xfer(HIGH + 32'h4, 1'b1, 32'h0, 4'b1111, acked, lat, rdata, strb, udata);
    check("above_high_noack", 256'(acked), 256'h0);
    xfer(BASE - 32'h4, 1'b0, 32'h12345678, 4'b1111, acked, lat, rdata, strb, udata);
    check("below_base_noack", 256'(acked), 256'h0);
    check("below_base_udata", 256'(user_data_out), 256'(exp_u));
    xfer(HIGH, 1'b1, 32'h0, 4'b1111, acked, lat, rdata, strb, udata);
    check("high_edge_ack", 256'(acked), 256'h1);
`ifndef REGBANK_SHADOW_EN
    // Without shadows, offset NUM_REGS*4 is just another unpopulated word.
    xfer(BASE + 32'h20, 1'b0, 32'h55555555, 4'b1111, acked, lat, rdata, strb, udata);
    check("commit_off_strobe", 256'(strb), 256'h0);
    check("commit_off_udata",  256'(udata), 256'(exp_u));
    xfer(BASE + 32'h20, 1'b1, 32'h0, 4'b1111, acked, lat, rdata, strb, udata);
    check("commit_off_rd", 256'(rdata), 256'h0);
`endif

    // ---- 5: select held 3 cycles, seqAddr=0 then seqAddr=1 ----
    repeat (3) @(negedge clk);
    ifc.OPB_ABus    = BASE + 32'h8;
    ifc.OPB_RNW     = 1'b1;
    ifc.OPB_seqAddr = 1'b0;
    ifc.OPB_select  = 1'b1;
    ack_pat = '0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      ack_pat[c] = ifc.Sl_xferAck;
      if (c == 2) ifc.OPB_select = 1'b0;
    end
    check("hold_noseq_acks", 256'(ack_pat), 256'b00001);

    repeat (3) @(negedge clk);
    ifc.OPB_seqAddr = 1'b1;
    ifc.OPB_select  = 1'b1;
    ack_pat = '0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      ack_pat[c] = ifc.Sl_xferAck;
      if (c == 2) ifc.OPB_select = 1'b0;
    end
    check("hold_seq_acks", 256'(ack_pat), 256'b00101);
    ifc.OPB_seqAddr = 1'b0;

    // ---- reset asserted during ACK aborts the transfer ----
    repeat (3) @(negedge clk);
    ifc.OPB_ABus   = BASE + 32'h8;
    ifc.OPB_RNW    = 1'b1;
    ifc.OPB_select = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_in_ack_ack",  256'(ifc.Sl_xferAck), 256'h0);
    check("rst_in_ack_dbus", 256'(ifc.Sl_DBus), 256'h0);
    ifc.OPB_select = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ack_udata", 256'(user_data_out), 256'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ack_after", 256'(ifc.Sl_xferAck), 256'h0);

`ifdef REGBANK_SHADOW_EN
    // ---- 6: shadow writes then commit ----
    xfer(BASE + 32'h0, 1'b0, 32'h5, 4'b1111, acked, lat, rdata, strb, udata);
    check("sh_wr0_udata", 256'(udata), 256'h0);
    xfer(BASE + 32'h4, 1'b0, 32'h7, 4'b1111, acked, lat, rdata, strb, udata);
    check("sh_wr1_udata",  256'(udata), 256'h0);
    check("sh_wr1_strobe", 256'(strb), 256'h0);
    xfer(BASE + 32'h0, 1'b1, 32'h0, 4'b1111, acked, lat, rdata, strb, udata);
    check("sh_rd0_data", 256'(rdata), 256'h5);
    xfer(BASE + 32'h20, 1'b0, 32'hFFFFFFFF, 4'b1111, acked, lat, rdata, strb, udata);
    exp_u = '0;
    exp_u[31:0]  = 32'h5;
    exp_u[63:32] = 32'h7;
    check("sh_commit_udata",  256'(udata), 256'(exp_u));
    check("sh_commit_strobe", 256'(strb), 256'h03);
    xfer(BASE + 32'h20, 1'b1, 32'h0, 4'b1111, acked, lat, rdata, strb, udata);
    check("sh_commit_rd", 256'(rdata), 256'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
